// File: rtl/rgb_fade_controller.sv
// rgb_fade_controller
// Ramps the three PWM duty values of the RGB mixer toward a target colour,
// one LSB per step, with a programmable step interval (step_div + 1 clocks).
// A new target is taken over a valid/ready handshake. The end of a fade is
// marked by a single-cycle done pulse.
//
// Optional feature: define RGB_FADE_RETARGET_EN to keep tgt_ready high while
// fading, so that a new target can replace the current one mid-fade.
//
// Handshake: a target is accepted on any rising edge where tgt_valid and
// tgt_ready are both high. tgt_ready comes from the state register only. An
// offer made while tgt_ready is low is ignored, so the source must keep it
// asserted until it is accepted.
module rgb_fade_controller #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic                 tgt_valid,
    output logic                 tgt_ready,
    input  logic [WIDTH-1:0]     tgt_r,
    input  logic [WIDTH-1:0]     tgt_g,
    input  logic [WIDTH-1:0]     tgt_b,
    input  logic [DIV_WIDTH-1:0] step_div,
    input  logic                 hold,
    output logic [WIDTH-1:0]     duty_r,
    output logic [WIDTH-1:0]     duty_g,
    output logic [WIDTH-1:0]     duty_b,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     tgt_r_q, tgt_g_q, tgt_b_q;
    logic [WIDTH-1:0]     duty_r_q, duty_g_q, duty_b_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] timer_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 accept;
    logic                 tick;
    logic [WIDTH-1:0]     eff_r, eff_g, eff_b;
    logic [WIDTH-1:0]     step_r_d, step_g_d, step_b_d;
    logic                 eq_now;
    logic                 eq_after;

    // Compare first, then step: a channel never overshoots and never wraps.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] tgt);
        logic [WIDTH-1:0] res;
        res = cur;
        if (cur < tgt) begin
            res = cur + 1'b1;
        end else if (cur > tgt) begin
            res = cur - 1'b1;
        end
        return res;
    endfunction

    // Ready is decoded from the state register only.
`ifdef RGB_FADE_RETARGET_EN
    assign tgt_ready = 1'b1;
`else
    assign tgt_ready = (state_q == IDLE);
`endif

    assign accept = tgt_valid && tgt_ready;
    assign tick   = (timer_q == '0);

    // Targets in force this cycle: a target being accepted takes effect at once.
    always_comb begin
        eff_r    = accept ? tgt_r : tgt_r_q;
        eff_g    = accept ? tgt_g : tgt_g_q;
        eff_b    = accept ? tgt_b : tgt_b_q;
        step_r_d = step_toward(duty_r_q, eff_r);
        step_g_d = step_toward(duty_g_q, eff_g);
        step_b_d = step_toward(duty_b_q, eff_b);
        eq_now   = (duty_r_q == eff_r) && (duty_g_q == eff_g) && (duty_b_q == eff_b);
        eq_after = (step_r_d == eff_r) && (step_g_d == eff_g) && (step_b_d == eff_b);
    end

    // Fade sequencer: state, targets, step timer, duties and status flags.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q  <= IDLE;
            tgt_r_q  <= '0;
            tgt_g_q  <= '0;
            tgt_b_q  <= '0;
            duty_r_q <= '0;
            duty_g_q <= '0;
            duty_b_q <= '0;
            div_q    <= '0;
            timer_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        tgt_r_q <= tgt_r;
                        tgt_g_q <= tgt_g;
                        tgt_b_q <= tgt_b;
                        div_q   <= step_div;
                        timer_q <= step_div;
                        if (eq_now) begin
                            // Already at the requested colour: no fade to run.
                            done_q <= 1'b1;
                        end else begin
                            state_q <= FADE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                FADE: begin
`ifdef RGB_FADE_RETARGET_EN
                    // A retarget swaps targets and the reload value but leaves
                    // the running step phase alone.
                    if (accept) begin
                        tgt_r_q <= tgt_r;
                        tgt_g_q <= tgt_g;
                        tgt_b_q <= tgt_b;
                        div_q   <= step_div;
                    end
`endif
                    if (accept && eq_now) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (!hold) begin
                        if (!tick) begin
                            timer_q <= timer_q - 1'b1;
                        end else begin
                            duty_r_q <= step_r_d;
                            duty_g_q <= step_g_d;
                            duty_b_q <= step_b_d;
                            timer_q  <= accept ? step_div : div_q;
                            if (eq_after) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign duty_r = duty_r_q;
    assign duty_g = duty_g_q;
    assign duty_b = duty_b_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_rgb_fade_controller.sv
// Self-checking bench for rgb_fade_controller. Directed fades with
// hand-computed end colours and done-pulse cycle numbers. The expected done
// events go into a queue that an independent monitor drains on each done pulse.
// Build with or without RGB_FADE_RETARGET_EN; the retarget case follows the macro.
module tb_rgb_fade_controller;

  localparam int W  = 8;
  localparam int DW = 16;
  localparam int EW = 3 * W + 32;

  logic          clk;
  logic          resetb;
  logic          tgt_valid;
  logic          tgt_ready;
  logic [W-1:0]  tgt_r, tgt_g, tgt_b;
  logic [DW-1:0] step_div;
  logic          hold;
  logic [W-1:0]  duty_r, duty_g, duty_b;
  logic          busy;
  logic          done;

  int            cyc;
  int            chk_cnt;
  int            pass_cnt;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  rgb_fade_controller #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_r     (tgt_r),
    .tgt_g     (tgt_g),
    .tgt_b     (tgt_b),
    .step_div  (step_div),
    .hold      (hold),
    .duty_r    (duty_r),
    .duty_g    (duty_g),
    .duty_b    (duty_b),
    .busy      (busy),
    .done      (done)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc holds the index of the most recent rising edge
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_exp(input logic [W-1:0] r, input logic [W-1:0] g,
                          input logic [W-1:0] b, input int at_cyc);
    exp_q.push_back({r, g, b, at_cyc[31:0]});
  endtask

  // scoreboard monitor: every done pulse must match the next expected event
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_duty_r", {24'd0, duty_r}, {24'd0, mon_e[EW-1 -: W]});
        check("sb_duty_g", {24'd0, duty_g}, {24'd0, mon_e[EW-1-W -: W]});
        check("sb_duty_b", {24'd0, duty_b}, {24'd0, mon_e[EW-1-2*W -: W]});
        check("sb_done_cycle", cyc, mon_e[31:0]);
      end
    end
  end

  // driver: call at a falling edge; returns just after the accepting edge
  task automatic offer(input logic [W-1:0] r, input logic [W-1:0] g,
                       input logic [W-1:0] b, input logic [DW-1:0] d, output int n);
    logic r_s;
    r_s       = 1'b0;
    tgt_r     = r;
    tgt_g     = g;
    tgt_b     = b;
    step_div  = d;
    tgt_valid = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      r_s = tgt_ready;
      @(posedge clk);
      if (r_s) break;
      @(negedge clk);
    end
    #1;
    n         = cyc;
    tgt_valid = 1'b0;
    if (!r_s) check("offer_accept_timeout", 32'd0, 32'd1);
  endtask

  // move to the falling edge that follows rising edge e
  task automatic at_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  // wait on falling edges for done, bounded
  task automatic wait_done(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done !== 1'b1 && k < budget);
    if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  // done must drop after one cycle
  task automatic pulse_end();
    @(negedge clk);
    check("done_single_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n, m, r0;
    chk_cnt   = 0;
    pass_cnt  = 0;
    resetb    = 1'b0;
    tgt_valid = 1'b0;
    tgt_r     = '0;
    tgt_g     = '0;
    tgt_b     = '0;
    step_div  = '0;
    hold      = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_duty_r", {24'd0, duty_r}, 32'd0);
    check("rst_duty_g", {24'd0, duty_g}, 32'd0);
    check("rst_duty_b", {24'd0, duty_b}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    resetb = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, tgt_ready}, 32'd1);

    // 0/0/0 -> 10/0/255, step_div 3: 255 steps of 4 cycles
    offer(8'd10, 8'd0, 8'd255, 16'd3, n);
    push_exp(8'd10, 8'd0, 8'd255, n + 1020);
    at_edge(n);
    check("t1_ready_low", {31'd0, tgt_ready}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    at_edge(n + 3);
    check("t1_pre_step_b", {24'd0, duty_b}, 32'd0);
    at_edge(n + 4);
    check("t1_first_step_r", {24'd0, duty_r}, 32'd1);
    check("t1_first_step_b", {24'd0, duty_b}, 32'd1);
    check("t1_first_step_g", {24'd0, duty_g}, 32'd0);
    wait_done(1100);
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    pulse_end();

    // reach 200/200/200 at one LSB per clock (largest distance 200)
    offer(8'd200, 8'd200, 8'd200, 16'd0, n);
    push_exp(8'd200, 8'd200, 8'd200, n + 200);
    wait_done(300);
    pulse_end();

    // 200/200/200 -> 198/200/202, step_div 0: two steps, busy for 2 cycles
    offer(8'd198, 8'd200, 8'd202, 16'd0, n);
    push_exp(8'd198, 8'd200, 8'd202, n + 2);
    at_edge(n);
    check("t2_busy_c0", {31'd0, busy}, 32'd1);
    at_edge(n + 1);
    check("t2_step1_r", {24'd0, duty_r}, 32'd199);
    check("t2_step1_g", {24'd0, duty_g}, 32'd200);
    check("t2_step1_b", {24'd0, duty_b}, 32'd201);
    check("t2_busy_c1", {31'd0, busy}, 32'd1);
    wait_done(10);
    check("t2_busy_c2", {31'd0, busy}, 32'd0);
    pulse_end();

    // target equal to the current duties: no fade, done next cycle
    offer(8'd198, 8'd200, 8'd202, 16'd5, n);
    push_exp(8'd198, 8'd200, 8'd202, n);
    wait_done(5);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_ready", {31'd0, tgt_ready}, 32'd1);
    pulse_end();

    // hold for 50 edges mid-fade, step_div 9: fade grows from 100 to 150 cycles
    offer(8'd208, 8'd200, 8'd202, 16'd9, n);
    push_exp(8'd208, 8'd200, 8'd202, n + 150);
    at_edge(n + 25);
    check("t4_pre_hold_r", {24'd0, duty_r}, 32'd200);
    hold = 1'b1;
    at_edge(n + 75);
    check("t4_held_r", {24'd0, duty_r}, 32'd200);
    check("t4_held_busy", {31'd0, busy}, 32'd1);
    hold = 1'b0;
    at_edge(n + 79);
    check("t4_timer_frozen_r", {24'd0, duty_r}, 32'd200);
    at_edge(n + 80);
    check("t4_resume_r", {24'd0, duty_r}, 32'd201);
    wait_done(200);
    pulse_end();

    // reset in the middle of a fade at duty_r 77
    offer(8'd0, 8'd0, 8'd0, 16'd0, n);
    push_exp(8'd0, 8'd0, 8'd0, n + 208);
    at_edge(n + 131);
    check("t5_mid_r", {24'd0, duty_r}, 32'd77);
    check("t5_mid_g", {24'd0, duty_g}, 32'd69);
    check("t5_mid_b", {24'd0, duty_b}, 32'd71);
    resetb = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t5_rst_r", {24'd0, duty_r}, 32'd0);
    check("t5_rst_g", {24'd0, duty_g}, 32'd0);
    check("t5_rst_b", {24'd0, duty_b}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_done", {31'd0, done}, 32'd0);
    resetb = 1'b1;
    r0 = cyc;
    offer(8'd5, 8'd6, 8'd7, 16'd0, n);
    check("t5_accept_after_release", n, r0 + 1);
    push_exp(8'd5, 8'd6, 8'd7, n + 7);
    at_edge(n);
    check("t5_busy", {31'd0, busy}, 32'd1);
    wait_done(20);
    pulse_end();

    // offer 0/0/0 while fading toward 255 with duty_r at 100
    offer(8'd255, 8'd0, 8'd0, 16'd0, n);
    push_exp(8'd255, 8'd0, 8'd0, n + 250);
    at_edge(n + 95);
    check("t6_at_100", {24'd0, duty_r}, 32'd100);
`ifdef RGB_FADE_RETARGET_EN
    check("t6_ready_in_fade", {31'd0, tgt_ready}, 32'd1);
    offer(8'd0, 8'd0, 8'd0, 16'd0, m);
    check("t6_retarget_edge", m, n + 96);
    exp_q.delete();
    push_exp(8'd0, 8'd0, 8'd0, m + 99);
    at_edge(m);
    check("t6_reversed_r", {24'd0, duty_r}, 32'd99);
    check("t6_busy", {31'd0, busy}, 32'd1);
    wait_done(200);
`else
    check("t6_ready_in_fade", {31'd0, tgt_ready}, 32'd0);
    offer(8'd0, 8'd0, 8'd0, 16'd0, m);
    check("t6_stalled_until_done", m, n + 251);
    push_exp(8'd0, 8'd0, 8'd0, m + 255);
    wait_done(400);
`endif
    check("t6_final_r", {24'd0, duty_r}, 32'd0);
    pulse_end();

    check("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
